// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin packet mux arbiter.
package mux_arb_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/response bundle between N requesters, the arbiter and one downstream sink.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic                   out_ready;
    logic [N_REQ-1:0]       grant;
    logic                   busy;

    // master drives requests and consumes the output beat; slave is the arbiter
    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, grant, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, grant, busy
    );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Rotating-priority pick: first valid requester at or after ptr, in cyclic order.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    // ptr is always below N_REQ, so one subtraction is enough to wrap
    always_comb begin
        int cand;
        logic [IDX_W-1:0] cidx;
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        cand        = 0;
        cidx        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cidx = IDX_W'(cand);
            if (!pick_any && req_valid[cidx]) begin
                pick_any          = 1'b1;
                pick_idx          = cidx;
                pick_onehot[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered output stage.
// A grant is held from arbitration until the owner's last beat transfers.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [N_REQ-1:0] grant_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             can_load;
    logic [N_REQ-1:0] ready_vec;
    logic             xfer;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_valid   (bus.req_valid),
        .ptr         (ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx == IDX_W'(i)) begin
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
                sel_last = bus.req_last[i];
            end
        end
    end

    // The output register can take a new beat when empty or draining this cycle
    assign can_load  = !out_valid_q || bus.out_ready;
    assign ready_vec = (state == BUSY && can_load) ? grant_q : '0;
    assign xfer      = |(bus.req_valid & ready_vec);

    assign bus.req_ready = ready_vec;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state == BUSY);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    // Output stage runs independently of state so a final beat drains after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_last_q  <= sel_last;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_onehot;
                        gidx    <= pick_idx;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer && sel_last) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        ptr     <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the data bits per beat.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: requester i offers a beat.
REQ-006 The block SHALL have port req_data, input, N_REQ*WIDTH bits: requester i data in slice [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port req_last, input, N_REQ bits: the offered beat ends requester i's packet.
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: requester i's beat is accepted this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the registered output beat is valid.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the registered output data.
REQ-011 The block SHALL have port out_last, output, 1 bit: the registered output beat is a packet end.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream accepts out_* this cycle.
REQ-013 The block SHALL have port grant, output, N_REQ bits: one-hot owner of the shared mux; all zero when no owner.
REQ-014 The block SHALL have port busy, output, 1 bit: the FSM is in the BUSY state.

Function
REQ-015 The FSM SHALL have two states, IDLE and BUSY.
REQ-016 In IDLE with any req_valid high, the block SHALL grant the first requester at or after index ptr (cyclic order), register the grant and go to BUSY on the next edge.
REQ-017 In IDLE, grant SHALL be zero and req_ready SHALL be all zero; arbitration costs exactly one cycle.
REQ-018 In IDLE with no req_valid high, the block SHALL stay in IDLE with ptr unchanged.
REQ-019 In BUSY, req_ready[g] SHALL equal (!out_valid || out_ready) for granted index g, and 0 for all other indices.
REQ-020 An input transfer SHALL occur when req_valid[g] && req_ready[g]; out_data and out_last SHALL load that beat and out_valid SHALL be 1 on the next edge, giving 1-cycle latency.
REQ-021 out_valid SHALL clear after out_ready when no new input transfer occurs in the same cycle; a transfer in that same cycle SHALL keep out_valid at 1 (back-to-back, no bubble).
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 An input transfer with req_last[g]=1 SHALL cause a return to IDLE on the next edge, with grant cleared and ptr set to (g+1) mod N_REQ; ptr N_REQ-1 SHALL wrap to 0.
REQ-024 Any pending out beat SHALL drain normally after the return to IDLE; arbitration MAY proceed while that beat drains.
REQ-025 If the owner drops req_valid mid-packet, grant SHALL be held and the block SHALL stall with no timeout and no re-arbitration.
REQ-026 Simultaneous requests SHALL be resolved only by round-robin order from ptr; a requester becoming valid in the same cycle as a release SHALL be eligible in the next IDLE cycle.
REQ-027 grant SHALL never have more than one bit set, and no requester SHALL starve: every requester is served within N_REQ packets.

Reset
REQ-028 While rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, ptr=0, grant=0, out_valid=0, out_data=0 and out_last=0, with req_ready and busy following those values.
REQ-029 A reset mid-packet SHALL discard the partial packet; the block SHALL resume from IDLE with ptr=0 after rst_n rises.

Structure
REQ-030 Package mux_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the default N_REQ and WIDTH constants.
REQ-031 The rotating-priority pick (req_valid and ptr in; one-hot and index out; purely combinational) SHALL be sub-module rr_priority_pick.
REQ-032 Data selection SHALL be an N_REQ:1 mux indexed by the granted index.

Verification
REQ-033 The bench SHALL cover reset then single requester: req_valid=0001, 3-beat packet 0x11/0x22/0x33, out_ready=1 -> grant=0001 one cycle after req_valid; out beats 0x11, 0x22, 0x33 on consecutive cycles; out_last only on 0x33; ptr=1 afterwards.
REQ-034 The bench SHALL cover all four requesting 1-beat packets continuously from ptr=0 -> grant order 0001, 0010, 0100, 1000, 0001 (wrap).
REQ-035 The bench SHALL cover backpressure: out_ready=0 for 5 cycles after the first beat 0xA5 -> out_data held at 0xA5, req_ready[g]=0, no beat lost or duplicated once out_ready=1.
REQ-036 The bench SHALL cover an owner gap: requester 2 owns, drops req_valid for 3 cycles mid-packet while requester 0 is valid -> grant stays 0100 and requester 0 is granted only after requester 2's last beat.
REQ-037 The bench SHALL cover reset mid-packet: rst_n=0 during beat 2 of 4 -> out_valid, grant and busy go to 0 without waiting for clk; after release, requester 0 wins first.
REQ-038 The bench SHALL check on every cycle that grant has at most one bit set, req_ready is a subset of grant, and out_data is stable while out_valid && !out_ready.
